// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART file loader: FSM encoding, protocol bytes
// and header length.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_SIZE  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DRAIN = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  localparam logic [7:0] REQ_SEND = 8'h02;
  localparam logic [7:0] REQ_RECV = 8'h03;
  localparam logic [7:0] REQ_END  = 8'h04;

  localparam int HDR_LEN = 4;

endpackage

// File: rtl/byte2word_packer.sv
// Packs a little-endian byte stream into one 32-bit word with per-lane strobes;
// cleared lanes read as zero so a partial final word carries no stale data.
module byte2word_packer (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  input  logic        i_flush,
  input  logic        i_clear,
  output logic [31:0] o_word,
  output logic [3:0]  o_strb,
  output logic        o_full
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic [3:0]  r_strb;

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lane <= '0;
      r_word <= '0;
      r_strb <= '0;
    end else if (i_clear || i_flush) begin
      r_lane <= '0;
      r_word <= '0;
      r_strb <= '0;
    end else if (i_valid) begin
      r_word[{r_lane, 3'b000} +: 8] <= i_byte;
      r_strb[r_lane]                <= 1'b1;
      r_lane                        <= r_lane + 2'd1;
    end
  end

  assign o_word = r_word;
  assign o_strb = r_strb;
  // High while lane 3 is next: the byte accepted now completes the word.
  assign o_full = (r_lane == 2'd3);

endmodule

// File: rtl/uart_file_loader.sv
// UART file-download engine: sends a request byte, reads a 4-byte LE size,
// then streams the file into memory as 32-bit LE words.
module uart_file_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_SIZE = 2**16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       file_size,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready
);

  localparam logic [31:0] MAX_SIZE_W = 32'(MAX_SIZE);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_cnt;
  logic [31:0]       r_file_size;
  logic [1:0]        r_hdr_idx;
  logic              r_err;

  logic              w_last_hdr;
  logic              w_last_byte;
  logic [31:0]       w_size_next;
  logic [31:0]       w_cnt_inc;
  logic              w_pk_valid;
  logic              w_pk_flush;
  logic              w_pk_clear;
  logic              w_pk_full;

  assign w_last_hdr  = (r_hdr_idx == 2'(HDR_LEN - 1));
  assign w_size_next = {rx_data, r_file_size[23:0]};
  assign w_cnt_inc   = r_cnt + 32'd1;
  assign w_last_byte = (w_cnt_inc == r_file_size);

  assign w_pk_valid  = (r_state == ST_DATA) && rx_valid;
  assign w_pk_flush  = (r_state == ST_WRITE) && mem_ready;
  assign w_pk_clear  = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: every signal driven here gets a default before the case, so no
  // state/input combination can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != ST_IDLE);
    done         = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = '0;
    rx_ready     = 1'b0;
    mem_valid    = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_REQ;
      ST_REQ: begin
        tx_valid = 1'b1;
        tx_data  = REQ_SEND;
        if (tx_ready) w_state_next = ST_SIZE;
      end
      ST_SIZE: begin
        rx_ready = 1'b1;
        if (rx_valid && w_last_hdr) begin
          if (w_size_next == '0)             w_state_next = ST_FIN;
          else if (w_size_next > MAX_SIZE_W) w_state_next = ST_DRAIN;
          else                               w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && (w_pk_full || w_last_byte)) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        mem_valid = 1'b1;
        if (mem_ready) w_state_next = (r_cnt == r_file_size) ? ST_FIN : ST_DATA;
      end
      ST_DRAIN: begin
        rx_ready = 1'b1;
        if (rx_valid && w_last_byte) w_state_next = ST_IDLE;
      end
      ST_FIN: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_file_size <= '0;
      r_hdr_idx   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_addr    <= {base_addr[ADDR_W-1:2], 2'b00};
          r_cnt     <= '0;
          r_hdr_idx <= '0;
        end
        ST_SIZE: if (rx_valid) begin
          r_file_size[{r_hdr_idx, 3'b000} +: 8] <= rx_data;
          r_hdr_idx <= r_hdr_idx + 2'd1;
          r_err     <= w_last_hdr && (w_size_next > MAX_SIZE_W);
        end
        // Oversized files are counted through DRAIN so the host stream stays in sync.
        ST_DATA, ST_DRAIN: if (rx_valid) r_cnt <= w_cnt_inc;
        ST_WRITE: if (mem_ready) r_addr <= r_addr + ADDR_W'(4);
        default: ;
      endcase
    end
  end

  byte2word_packer u_packer (
    .clk     (clk),
    .resetn  (resetn),
    .i_byte  (rx_data),
    .i_valid (w_pk_valid),
    .i_flush (w_pk_flush),
    .i_clear (w_pk_clear),
    .o_word  (mem_wdata),
    .o_strb  (mem_wstrb),
    .o_full  (w_pk_full)
  );

  assign file_size = r_file_size;
  assign err       = r_err;
  assign mem_addr  = r_addr;

endmodule

// File: tb/tb_uart_file_loader.sv
// Self-checking bench for uart_file_loader: a host model streams files over
// the rx port and memory writes are compared against a word-packing model.
`timescale 1ns/1ps
module tb_uart_file_loader;

  localparam int AW   = 32;
  localparam int MAXS = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;
  typedef wr_t        wq_t[$];
  typedef logic [7:0] bq_t[$];

  logic          clk       = 1'b0;
  logic          resetn    = 1'b0;
  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, err;
  logic [31:0]   file_size;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready  = 1'b0;
  logic          rx_valid  = 1'b0;
  logic [7:0]    rx_data   = '0;
  logic          rx_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  // Observations owned by the monitor; cleared when clr_seq changes.
  int         clr_seq = 0, clr_seen = 0;
  int         stall_goal = 0;
  int         cyc = 0, rx_n = 0, hdr_cyc = -1, done_cyc = -1;
  int         done_n = 0, err_n = 0, stall_n = 0, viol_n = 0;
  logic [7:0] tx_q[$];
  wr_t        got_w[$];

  uart_file_loader #(.ADDR_W(AW), .MAX_SIZE(MAXS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .file_size (file_size),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready)
  );

  initial forever #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; handshakes are observed at the
  // falling edge, where they are stable until the edge that completes them.
  initial forever begin
    @(posedge clk); #1;
    tx_ready  = ($urandom_range(0, 3) != 0);
    mem_ready = !(mem_valid && (stall_n < stall_goal));
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (clr_seen != clr_seq) begin
      clr_seen = clr_seq;
      rx_n = 0; hdr_cyc = -1; done_cyc = -1;
      done_n = 0; err_n = 0; stall_n = 0; viol_n = 0;
      tx_q.delete();
      got_w.delete();
    end
    if (resetn) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (rx_valid && rx_ready) begin
        rx_n++;
        if (rx_n == 4) hdr_cyc = cyc;
      end
      if (mem_valid && mem_ready)  got_w.push_back({mem_addr, mem_wdata, mem_wstrb});
      if (mem_valid && !mem_ready) stall_n++;
      if (mem_valid && rx_ready)   viol_n++;
      if (done && done_n == 0) done_cyc = cyc;
      if (done) done_n++;
      if (err)  err_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Reference: file bytes grouped four at a time into LE words at base+4*i.
  function automatic wq_t model(input logic [31:0] base, input bq_t d);
    wq_t q;
    int  sz;
    sz = d.size();
    if (sz > MAXS) return q;
    for (int w = 0; 4 * w < sz; w++) begin
      wr_t e;
      e.addr = base + 32'(4 * w);
      e.data = '0;
      e.strb = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < sz) begin
          e.data    = e.data | (32'(d[4*w+k]) << (8 * k));
          e.strb[k] = 1'b1;
        end
      q.push_back(e);
    end
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t d;
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    return d;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 1000) begin @(negedge clk); n++; end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL rx_accept_timeout byte %02h rx_ready %b required 1", b, rx_ready);
    end
    @(posedge clk); #1;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic begin_transfer(input logic [31:0] base, input logic [31:0] sz, input logic dbl);
    int n;
    clr_seq++;
    @(negedge clk);
    @(posedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (tx_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
    if (tx_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL req_timeout tx count 0 required 1");
    end
    @(posedge clk); #1;
    if (dbl) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 4; i++) send_byte(sz[8*i +: 8], $urandom_range(0, 1));
  endtask

  task automatic finish_transfer(input bq_t d, input int gap_max);
    int n;
    foreach (d[i]) send_byte(d[i], $urandom_range(0, gap_max));
    rx_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy 1 required 0");
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_transfer(input logic [31:0] base, input bq_t d, input int gap_max, input logic dbl);
    begin_transfer(base, 32'(d.size()), dbl);
    finish_transfer(d, gap_max);
  endtask

  task automatic check_idle_outputs_now(input string nm);
    // Inline comparisons of every output against its reset value.
    checks++;
    if ({busy, done, err, tx_valid, rx_ready, mem_valid} !== 6'b0) begin
      errors++;
      $display("FAIL %s_ctrl got %b required 000000", nm, {busy, done, err, tx_valid, rx_ready, mem_valid});
    end
    checks++;
    if ({tx_data, file_size, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      errors++;
      $display("FAIL %s_data tx %h size %h addr %h wdata %h wstrb %h required all 0",
               nm, tx_data, file_size, mem_addr, mem_wdata, mem_wstrb);
    end
  endtask

  task automatic test_reset();
    #12;
    check_idle_outputs_now("reset_held");
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs_now("reset_released");
    @(posedge clk); #1;
  endtask

  task automatic test_size8();
    bq_t d;
    wq_t exp;
    for (int i = 0; i < 8; i++) d.push_back(8'h11 + 8'(i));
    do_transfer(32'h100, d, 2, 1'b0);
    exp = model(32'h100, d);
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h02) begin
      errors++; $display("FAIL size8_req got count %0d required one 02", tx_q.size());
    end
    checks++;
    if (got_w.size() != exp.size()) begin
      errors++; $display("FAIL size8_nwrites got %0d required %0d", got_w.size(), exp.size());
    end
    foreach (exp[i]) if (i < got_w.size()) begin
      checks++;
      if (got_w[i] !== exp[i]) begin
        errors++;
        $display("FAIL size8_write%0d got %h/%h/%h required %h/%h/%h", i, got_w[i].addr,
                 got_w[i].data, got_w[i].strb, exp[i].addr, exp[i].data, exp[i].strb);
      end
    end
    checks++;
    if (done_n != 1 || err_n != 0) begin
      errors++; $display("FAIL size8_pulses got done %0d err %0d required 1 0", done_n, err_n);
    end
    checks++;
    if (file_size !== 32'd8) begin
      errors++; $display("FAIL size8_file_size got %0d required 8", file_size);
    end
  endtask

  task automatic test_size5();
    bq_t d;
    wq_t exp;
    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_transfer(32'h2000, d, 2, 1'b0);
    exp = model(32'h2000, d);
    checks++;
    if (got_w.size() != exp.size()) begin
      errors++; $display("FAIL size5_nwrites got %0d required %0d", got_w.size(), exp.size());
    end
    foreach (exp[i]) if (i < got_w.size()) begin
      checks++;
      if (got_w[i] !== exp[i]) begin
        errors++;
        $display("FAIL size5_write%0d got %h/%h/%h required %h/%h/%h", i, got_w[i].addr,
                 got_w[i].data, got_w[i].strb, exp[i].addr, exp[i].data, exp[i].strb);
      end
    end
    checks++;
    if (done_n != 1) begin
      errors++; $display("FAIL size5_done got %0d required 1", done_n);
    end
  endtask

  task automatic test_size0();
    bq_t d;
    do_transfer(32'h40, d, 1, 1'b0);
    checks++;
    if (tx_q.size() != 1) begin
      errors++; $display("FAIL size0_req got count %0d required 1", tx_q.size());
    end
    checks++;
    if (got_w.size() != 0) begin
      errors++; $display("FAIL size0_nwrites got %0d required 0", got_w.size());
    end
    checks++;
    if (done_n != 1 || done_cyc - hdr_cyc != 1) begin
      errors++;
      $display("FAIL size0_done_timing got count %0d delay %0d required 1 1", done_n, done_cyc - hdr_cyc);
    end
  endtask

  task automatic test_oversize();
    bq_t d;
    wq_t exp;
    d = rand_bytes(MAXS + 1);
    do_transfer(32'h300, d, 1, 1'b0);
    checks++;
    if (err_n != 1 || done_n != 0) begin
      errors++; $display("FAIL over_pulses got err %0d done %0d required 1 0", err_n, done_n);
    end
    checks++;
    if (got_w.size() != 0 || rx_n != MAXS + 5) begin
      errors++;
      $display("FAIL over_drain got writes %0d bytes %0d required 0 %0d", got_w.size(), rx_n, MAXS + 5);
    end
    checks++;
    if (busy !== 1'b0 || file_size !== 32'(MAXS + 1)) begin
      errors++; $display("FAIL over_end got busy %b size %0d required 0 %0d", busy, file_size, MAXS + 1);
    end
    // Exactly MAX_SIZE is still a valid file.
    d = rand_bytes(MAXS);
    do_transfer(32'h800, d, 1, 1'b0);
    exp = model(32'h800, d);
    checks++;
    if (got_w.size() != exp.size() || err_n != 0 || done_n != 1) begin
      errors++;
      $display("FAIL max_size got writes %0d err %0d done %0d required %0d 0 1",
               got_w.size(), err_n, done_n, exp.size());
    end
    foreach (exp[i]) if (i < got_w.size()) begin
      checks++;
      if (got_w[i] !== exp[i]) begin
        errors++;
        $display("FAIL max_write%0d got %h/%h/%h required %h/%h/%h", i, got_w[i].addr,
                 got_w[i].data, got_w[i].strb, exp[i].addr, exp[i].data, exp[i].strb);
      end
    end
  endtask

  task automatic test_stall();
    bq_t d;
    wq_t exp;
    for (int i = 0; i < 8; i++) d.push_back(8'h11 + 8'(i));
    stall_goal = 10;
    do_transfer(32'h100, d, 0, 1'b0);
    stall_goal = 0;
    exp = model(32'h100, d);
    checks++;
    if (stall_n != 10 || viol_n != 0) begin
      errors++;
      $display("FAIL stall_rx_ready got stall %0d ready_during_write %0d required 10 0", stall_n, viol_n);
    end
    checks++;
    if (got_w.size() != exp.size()) begin
      errors++; $display("FAIL stall_nwrites got %0d required %0d", got_w.size(), exp.size());
    end
    foreach (exp[i]) if (i < got_w.size()) begin
      checks++;
      if (got_w[i] !== exp[i]) begin
        errors++;
        $display("FAIL stall_write%0d got %h/%h/%h required %h/%h/%h", i, got_w[i].addr,
                 got_w[i].data, got_w[i].strb, exp[i].addr, exp[i].data, exp[i].strb);
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t d;
    wq_t exp;
    begin_transfer(32'h100, 32'd8, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h11 + 8'(i), 0);
    rx_valid = 1'b0;
    #3 resetn = 1'b0;
    #1 check_idle_outputs_now("reset_mid");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) d.push_back(8'h11 + 8'(i));
    do_transfer(32'h100, d, 1, 1'b1);
    exp = model(32'h100, d);
    checks++;
    if (tx_q.size() != 1) begin
      errors++; $display("FAIL rerun_req got count %0d required 1", tx_q.size());
    end
    checks++;
    if (got_w.size() != exp.size() || done_n != 1 || file_size !== 32'd8) begin
      errors++;
      $display("FAIL rerun_summary got writes %0d done %0d size %0d required %0d 1 8",
               got_w.size(), done_n, file_size, exp.size());
    end
    foreach (exp[i]) if (i < got_w.size()) begin
      checks++;
      if (got_w[i] !== exp[i]) begin
        errors++;
        $display("FAIL rerun_write%0d got %h/%h/%h required %h/%h/%h", i, got_w[i].addr,
                 got_w[i].data, got_w[i].strb, exp[i].addr, exp[i].data, exp[i].strb);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      bq_t         d;
      wq_t         exp;
      logic [31:0] base;
      int          sz;
      sz   = $urandom_range(1, MAXS);
      base = $urandom & 32'h0FFF_FFFC;
      d    = rand_bytes(sz);
      do_transfer(base, d, 2, 1'b0);
      exp  = model(base, d);
      checks++;
      if (got_w.size() != exp.size() || done_n != 1 || err_n != 0 || file_size !== 32'(sz)) begin
        errors++;
        $display("FAIL rand%0d_summary got writes %0d done %0d err %0d size %0d required %0d 1 0 %0d",
                 t, got_w.size(), done_n, err_n, file_size, exp.size(), sz);
      end
      foreach (exp[i]) if (i < got_w.size()) begin
        checks++;
        if (got_w[i] !== exp[i]) begin
          errors++;
          $display("FAIL rand%0d_write%0d got %h/%h/%h required %h/%h/%h", t, i, got_w[i].addr,
                   got_w[i].data, got_w[i].strb, exp[i].addr, exp[i].data, exp[i].strb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_size8();
    test_size5();
    test_size0();
    test_oversize();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
